id_ex_operand_stage: RTL
========================

Name: id_ex_operand_stage

Overview:
- Pipeline register between decode and the ALU; it directly drives `alu_op`, `in_a` and `in_b` of the execute-stage ALU.
- Captures the decoded instruction and resolves RAW hazards at capture time by forwarding. Sources, in priority order: the ALU result of the instruction currently in EX, then the MEM-stage result, then register-file data.
- Supports stall (hold) and flush (bubble insert).

Parameters:
- XLEN, 32, datapath width
- REG_AW, 5, register address width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  hold all outputs this cycle
- flush  in  1  replace the stage contents with a bubble; priority over stall
- id_valid  in  1  decode slot holds a real instruction
- id_alu_op  in  4  ALU operation code
- id_rs1_addr  in  REG_AW  source register 1
- id_rs2_addr  in  REG_AW  source register 2
- id_rs1_data  in  XLEN  register-file read data 1
- id_rs2_data  in  XLEN  register-file read data 2
- id_imm  in  XLEN  sign-extended immediate
- id_alu_src  in  1  1 selects id_imm for the B operand
- id_rd_addr  in  REG_AW  destination register
- id_reg_write  in  1  instruction writes rd
- alu_result  in  XLEN  current ALU output, i.e. the result of the instruction held in this stage
- mem_reg_write  in  1  MEM-stage instruction writes rd
- mem_rd_addr  in  REG_AW  MEM-stage destination register
- mem_data  in  XLEN  MEM-stage result
- ex_valid  out  1  stage holds a real instruction
- alu_op  out  4  to ALU
- in_a  out  XLEN  to ALU
- in_b  out  XLEN  to ALU
- ex_store_data  out  XLEN  forwarded rs2 value, for stores
- ex_rd_addr  out  REG_AW  destination register
- ex_reg_write  out  1  write enable, gated by valid

Behaviour:
- Reset: all outputs are 0 asynchronously; alu_op=4'b0000 (AND), giving a bubble.
- Latency: 1 cycle. Decode inputs at edge N appear on the outputs after edge N.

Forwarding (combinational, evaluated before capture), applied independently for rs1 and rs2:
- EX hit when ex_valid && ex_reg_write && ex_rd_addr==rsX && rsX!=0. The value used is alu_result.
- MEM hit when mem_reg_write && mem_rd_addr==rsX && rsX!=0. The value used is mem_data.
- Priority: EX hit > MEM hit > id_rsX_data.
- x0 is never forwarded. An operand with rsX==0 takes id_rsX_data unmodified.

Operand formation:
- in_a = fwd_rs1.
- in_b = id_alu_src ? id_imm : fwd_rs2.
- ex_store_data = fwd_rs2, always.

Edge update priority:
- rst: outputs cleared as at reset.
- flush: bubble. ex_valid=0, ex_reg_write=0, alu_op=0000, in_a=in_b=ex_store_data=0, ex_rd_addr=0.
- stall: all outputs hold. The held operands were already resolved at their capture and are not re-forwarded.
- id_valid=0: bubble, identical to flush.
- Otherwise: capture the decoded instruction. ex_valid=1 and ex_reg_write=id_reg_write.

Other rules:
- flush && stall in the same cycle gives a bubble.
- alu_op is passed through unmodified, including undefined codes such as 4'b1110; the ALU outputs 0 for these.
- No arithmetic is performed in this block; widths are fixed at XLEN and there is no extension.
- rst asserted mid-operation clears the stage immediately, independent of clk.

Decomposition:
- riscv_pkg holds:
  - XLEN and REG_AW
  - typedef alu_op_t, a 4-bit enum: ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110
  - constant BUBBLE_OP=ALU_AND
- One combinational sub-module, operand_fwd_unit, instantiated twice (rs1, rs2). Inputs are rs addr, rf data, the EX and MEM hazard inputs; output is the forwarded value.

Test Plan:
1. Reset mid-run: rst pulsed between clock edges while ex_valid=1 -> all outputs 0 immediately. After release, the first valid capture of ADD rs1=3 (data 5), rs2=4 (data 6) gives alu_op=0010, in_a=5, in_b=6.
2. EX forwarding on back-to-back RAW:
   - Stage holds ADD with rd=5 and alu_result=32'd11.
   - Next instruction is SUB with rs1=5 (rf data 0), rs2=6 (rf data 3).
   - Expected after the edge: in_a=11, in_b=3, alu_op=0110.
3. EX over MEM priority:
   - Forward sources: mem_rd_addr=5 with mem_data=77; EX rd=5 with alu_result=11.
   - Expected: in_a=11.
   - Repeat with ex_valid=0 -> in_a=77.
4. x0 guard: rs1=0 with EX rd=0 and reg_write=1, alu_result=32'hdeadbeef, id_rs1_data=0 -> in_a=0.
5. Immediate select: id_alu_src=1, imm=32'hfffffff0, rs2 forwarded to 9 -> in_b=32'hfffffff0, ex_store_data=9.
6. Stall/flush:
   - stall=1 for 3 cycles while decode inputs change -> outputs unchanged.
   - stall=1 and flush=1 together -> ex_valid=0, ex_reg_write=0, alu_op=0000, in_a=in_b=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, ALU opcodes and the bubble opcode
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;
  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110
  } alu_op_t;
  localparam alu_op_t BUBBLE_OP = ALU_AND;
endpackage

// File: rtl/operand_fwd_unit.sv
// operand_fwd_unit: resolves one source operand from EX, MEM or register-file data
module operand_fwd_unit #(
  parameter int XLEN = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [XLEN-1:0]   rf_data,
  input  logic              ex_valid,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic [XLEN-1:0]   alu_result,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic [XLEN-1:0]   mem_data,
  output logic [XLEN-1:0]   fwd_data
);
  logic ex_hit, mem_hit;
  always_comb begin
    ex_hit = ex_valid && ex_reg_write && ex_rd_addr == rs_addr && rs_addr != '0;
    mem_hit = mem_reg_write && mem_rd_addr == rs_addr && rs_addr != '0;
    fwd_data = ex_hit ? alu_result : mem_hit ? mem_data : rf_data;
  end
endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: decode-to-ALU pipeline register with capture-time forwarding
module id_ex_operand_stage #(
  parameter int XLEN = riscv_pkg::XLEN,
  parameter int REG_AW = riscv_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [3:0]        id_alu_op,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic              id_alu_src,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic              id_reg_write,
  input  logic [XLEN-1:0]   alu_result,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic [XLEN-1:0]   mem_data,
  output logic              ex_valid,
  output logic [3:0]        alu_op,
  output logic [XLEN-1:0]   in_a,
  output logic [XLEN-1:0]   in_b,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_reg_write
);
  import riscv_pkg::*;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;
  operand_fwd_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
    .rs_addr(id_rs1_addr), .rf_data(id_rs1_data),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_rd_addr(ex_rd_addr), .alu_result(alu_result),
    .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr), .mem_data(mem_data),
    .fwd_data(fwd_rs1)
  );
  operand_fwd_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
    .rs_addr(id_rs2_addr), .rf_data(id_rs2_data),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_rd_addr(ex_rd_addr), .alu_result(alu_result),
    .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr), .mem_data(mem_data),
    .fwd_data(fwd_rs2)
  );
  // flush and an empty decode slot both insert the same bubble; flush wins over stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid <= 1'b0;
      alu_op <= BUBBLE_OP;
      in_a <= '0;
      in_b <= '0;
      ex_store_data <= '0;
      ex_rd_addr <= '0;
      ex_reg_write <= 1'b0;
    end else if (flush || (!stall && !id_valid)) begin
      ex_valid <= 1'b0;
      alu_op <= BUBBLE_OP;
      in_a <= '0;
      in_b <= '0;
      ex_store_data <= '0;
      ex_rd_addr <= '0;
      ex_reg_write <= 1'b0;
    end else if (!stall) begin
      ex_valid <= 1'b1;
      alu_op <= id_alu_op;
      in_a <= fwd_rs1;
      in_b <= id_alu_src ? id_imm : fwd_rs2;
      ex_store_data <= fwd_rs2;
      ex_rd_addr <= id_rd_addr;
      ex_reg_write <= id_reg_write;
    end
  end
endmodule
